alu_arbiter: RTL



---
 rtl/alu_arbiter_pkg.sv | 15 +
 rtl/alu_arbiter_if.sv | 31 +++
 rtl/alu_arbiter_rr_pick.sv | 21 ++
 rtl/alu_arbiter.sv | 65 ++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: alu control codes, datapath width and response FSM states
package alu_arbiter_pkg;
  localparam int ALU_W = 16;
  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_PADDSB = 4'b0010,
    ALU_NAND   = 4'b0100,
    ALU_XOR    = 4'b1000,
    ALU_SLL    = 4'b1100,
    ALU_SRA    = 4'b1101,
    ALU_SRL    = 4'b1110
  } alu_ctrl_e;
  typedef enum logic {EMPTY, FULL} state_e;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, alu and response bundle shared by the arbiter and its parent
interface alu_arbiter_if import alu_arbiter_pkg::*; #(parameter int NREQ = 2, parameter int IDW = 1);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [ALU_W*NREQ-1:0] req_a;
  logic [ALU_W*NREQ-1:0] req_b;
  logic [4*NREQ-1:0]     req_ctrl;
  logic [NREQ-1:0]       req_flag_we;
  logic [ALU_W-1:0]      alu_a;
  logic [ALU_W-1:0]      alu_b;
  logic [3:0]            alu_ctrl;
  logic [ALU_W-1:0]      alu_result;
  logic                  alu_v;
  logic                  alu_n;
  logic                  alu_z;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [ALU_W-1:0]      rsp_result;
  logic                  flag_v;
  logic                  flag_n;
  logic                  flag_z;
  modport slave (
    input  req_valid, req_a, req_b, req_ctrl, req_flag_we, alu_result, alu_v, alu_n, alu_z, rsp_ready,
    output req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, rsp_result, flag_v, flag_n, flag_z
  );
  modport master (
    output req_valid, req_a, req_b, req_ctrl, req_flag_we, alu_result, alu_v, alu_n, alu_z, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, rsp_result, flag_v, flag_n, flag_z
  );
endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// alu_arbiter_rr_pick: one-hot pick of the first valid requester after the pointer, wrapping
module alu_arbiter_rr_pick #(parameter int N = 2, parameter int W = 1) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant
);
  // scan N slots starting just past the last winner
  always_comb begin
    int idx;
    logic found;
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu among NREQ requesters, registers result/id, holds V/N/Z flags (ALU_ARB_FIXED_PRIO_EN selects fixed priority)
module alu_arbiter import alu_arbiter_pkg::*; #(parameter int NREQ = 2, parameter int IDW = 1) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);
  if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
    $error("alu_arbiter: NREQ must be 2..4");
  end
  if (IDW < $clog2(NREQ)) begin : g_bad_idw
    $error("alu_arbiter: IDW too narrow for NREQ");
  end
  state_e           state, state_n;
  logic [IDW-1:0]   ptr, gidx, rsp_id;
  logic [NREQ-1:0]  grant;
  logic [ALU_W-1:0] rsp_result;
  logic             can_accept, accept, any, fv, fn, fz;
  alu_arbiter_rr_pick #(.N(NREQ), .W(IDW)) u_pick (.valid(bus.req_valid), .ptr(ptr), .grant(grant));
  assign any        = |grant;
  assign can_accept = rst_n && (state == EMPTY || bus.rsp_ready);
  assign accept     = can_accept && any;
  assign bus.req_ready  = can_accept ? grant : '0;
  assign bus.alu_a      = any ? bus.req_a[gidx*ALU_W +: ALU_W] : '0;
  assign bus.alu_b      = any ? bus.req_b[gidx*ALU_W +: ALU_W] : '0;
  assign bus.alu_ctrl   = any ? bus.req_ctrl[gidx*4 +: 4] : '0;
  assign bus.rsp_valid  = state == FULL;
  assign bus.rsp_id     = rsp_id;
  assign bus.rsp_result = rsp_result;
  assign bus.flag_v     = fv;
  assign bus.flag_n     = fn;
  assign bus.flag_z     = fz;
  // one-hot grant to requester index
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) if (grant[i]) gidx = IDW'(i);
  end
  // response slot: reload on accept, drain when consumer takes it with nothing new
  always_comb begin
    state_n = state;
    if (accept) state_n = FULL;
    else if (state == FULL && bus.rsp_ready) state_n = EMPTY;
  end
  // state, response register, flag register and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      rsp_result <= '0;
      rsp_id     <= '0;
      {fv, fn, fz} <= 3'b000;
      ptr        <= IDW'(NREQ - 1);
    end else begin
      state <= state_n;
      if (accept) begin
        rsp_result <= bus.alu_result;
        rsp_id     <= gidx;
        if (bus.req_flag_we[gidx]) {fv, fn, fz} <= {bus.alu_v, bus.alu_n, bus.alu_z};
`ifdef ALU_ARB_FIXED_PRIO_EN
        ptr <= ptr;
`else
        ptr <= gidx;
`endif
      end
    end
  end
endmodule
